// File: rtl/adc_mac_integrator.sv
// rtl/adc_mac_integrator.sv - ADC sample delay/integrate/shift/saturate block
module adc_mac_integrator #(
    parameter int num_bits = 16,
    parameter int acc_bits = num_bits + 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [num_bits-1:0] adc_tdata,
    input  logic                adc_tvalid,
    input  logic [7:0]          cfg_delay,
    input  logic [7:0]          cfg_len,
    input  logic [3:0]          cfg_shift,
    output logic [num_bits-1:0] val_out,
    output logic                val_valid,
    output logic                sat_err,
    output logic [1:0]          state_out
);

    localparam logic [1:0] st_idle  = 2'd0;
    localparam logic [1:0] st_delay = 2'd1;
    localparam logic [1:0] st_integ = 2'd2;

    // Output clamp limits expressed at accumulator width.
    localparam logic signed [acc_bits-1:0] sat_max =
        {{(acc_bits-num_bits+1){1'b0}}, {(num_bits-1){1'b1}}};
    localparam logic signed [acc_bits-1:0] sat_min =
        {{(acc_bits-num_bits+1){1'b1}}, {(num_bits-1){1'b0}}};

    logic [1:0]                 state;
    logic signed [acc_bits-1:0] acc;
    logic [7:0]                 cnt;
    logic [7:0]                 delay_q;
    logic [7:0]                 len_q;
    logic [3:0]                 shift_q;

    logic signed [acc_bits-1:0] sample_ext;
    logic signed [acc_bits-1:0] sum;
    logic signed [acc_bits-1:0] shifted;
    logic signed [acc_bits-1:0] sat_val;
    logic                       sat_hit;
    logic                       last_sample;

    assign state_out = state;

    // Running sum including the current sample, scaled and clamped to output range.
    always_comb begin
        sample_ext  = {{(acc_bits-num_bits){adc_tdata[num_bits-1]}}, adc_tdata};
        sum         = acc + sample_ext;
        shifted     = sum >>> shift_q;
        sat_val     = shifted;
        sat_hit     = 1'b0;
        last_sample = ((cnt + 8'd1) == len_q);
        if (shifted > sat_max) begin
            sat_val = sat_max;
            sat_hit = 1'b1;
        end else if (shifted < sat_min) begin
            sat_val = sat_min;
            sat_hit = 1'b1;
        end
    end

    // Sequencer: latch config on run start, skip delay samples, then integrate in windows of len.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= st_idle;
            acc       <= '0;
            cnt       <= '0;
            delay_q   <= '0;
            len_q     <= '0;
            shift_q   <= '0;
            val_out   <= '0;
            val_valid <= 1'b0;
            sat_err   <= 1'b0;
        end else begin
            val_valid <= 1'b0;
            case (state)
                st_idle: begin
                    if (run) begin
                        delay_q <= cfg_delay;
                        len_q   <= (cfg_len == 8'd0) ? 8'd1 : cfg_len;
                        shift_q <= cfg_shift;
                        acc     <= '0;
                        cnt     <= '0;
                        sat_err <= 1'b0;
                        state   <= (cfg_delay != 8'd0) ? st_delay : st_integ;
                    end
                end
                st_delay: begin
                    if (!run) begin
                        state <= st_idle;
                        cnt   <= '0;
                    end else if (adc_tvalid) begin
                        if ((cnt + 8'd1) == delay_q) begin
                            state <= st_integ;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                st_integ: begin
                    if (adc_tvalid) begin
                        if (last_sample) begin
                            val_out   <= sat_val[num_bits-1:0];
                            val_valid <= 1'b1;
                            if (sat_hit) begin
                                sat_err <= 1'b1;
                            end
                            acc <= '0;
                            cnt <= '0;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + 8'd1;
                        end
                    end
                    // A window completing on this edge still strobes; any partial sum is dropped.
                    if (!run) begin
                        state <= st_idle;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_mac_integrator.sv
// tb/tb_adc_mac_integrator.sv - scoreboard bench for adc_mac_integrator
module tb_adc_mac_integrator;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] adc_tdata;
    logic        adc_tvalid;
    logic [7:0]  cfg_delay;
    logic [7:0]  cfg_len;
    logic [3:0]  cfg_shift;
    logic [15:0] val_out;
    logic        val_valid;
    logic        sat_err;
    logic [1:0]  state_out;

    int passed = 0;
    int total  = 0;
    longint exp_q[$];

    adc_mac_integrator #(.num_bits(16), .acc_bits(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .adc_tdata (adc_tdata),
        .adc_tvalid(adc_tvalid),
        .cfg_delay (cfg_delay),
        .cfg_len   (cfg_len),
        .cfg_shift (cfg_shift),
        .val_out   (val_out),
        .val_valid (val_valid),
        .sat_err   (sat_err),
        .state_out (state_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic longint model(input longint s, input int sh);
        longint r;
        r = s >>> sh;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic start_run(input int d, input int l, input int s);
        cfg_delay  = d[7:0];
        cfg_len    = l[7:0];
        cfg_shift  = s[3:0];
        adc_tvalid = 1'b0;
        run        = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input int x);
        adc_tdata  = x[15:0];
        adc_tvalid = 1'b1;
        @(negedge clk);
        adc_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (val_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", $signed(val_out), 99999);
            end else begin
                check("val_out", $signed(val_out), exp_q.pop_front());
            end
        end
    end

    initial begin
        longint acc;
        int     cnt;
        rst = 1'b1; run = 1'b0; adc_tdata = '0; adc_tvalid = 1'b0;
        cfg_delay = 8'd0; cfg_len = 8'd0; cfg_shift = 4'd0;
        idle(2);
        check("rst_state", state_out, 0);
        check("rst_val_out", val_out, 0);
        check("rst_val_valid", val_valid, 0);
        check("rst_sat_err", sat_err, 0);
        rst = 1'b0;
        idle(1);

        // delay=3 len=4: samples 1..11, first three discarded; cfg changes mid-run ignored
        start_run(3, 4, 0);
        check("state_delay", state_out, 1);
        cfg_len = 8'd1; cfg_delay = 8'd0; cfg_shift = 4'd3;
        acc = 0; cnt = 0;
        for (int i = 1; i <= 11; i++) begin
            if (i > 3) begin
                acc += i; cnt++;
                if (cnt == 4) begin
                    exp_q.push_back(model(acc, 0));
                    acc = 0; cnt = 0;
                end
            end
            send(i);
        end
        idle(3);
        check("state_integ", state_out, 2);
        check("hold_val_out", $signed(val_out), 38);
        run = 1'b0;
        idle(2);

        // len=2 shift=1 with a tvalid gap: (100-301)>>>1 = -101
        start_run(0, 2, 1);
        send(100);
        idle(2);
        exp_q.push_back(model(100 - 301, 1));
        send(-301);
        idle(3);
        run = 1'b0;
        idle(2);

        // saturation: four full-scale samples
        start_run(0, 4, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(model(4 * 32767, 0));
            send(32767);
        end
        idle(2);
        check("sat_err_set", sat_err, 1);
        run = 1'b0;
        idle(3);
        check("sat_err_sticky", sat_err, 1);

        // len=0 acts as 1
        start_run(0, 0, 0);
        check("sat_err_cleared", sat_err, 0);
        exp_q.push_back(-5);
        send(-5);
        exp_q.push_back(7);
        send(7);
        idle(2);
        run = 1'b0;
        idle(2);

        // run drop discards a partial sum
        start_run(0, 4, 0);
        send(1);
        send(2);
        run = 1'b0;
        idle(1);
        check("run_drop_idle", state_out, 0);
        idle(3);
        start_run(0, 2, 0);
        send(10);
        exp_q.push_back(30);
        send(20);
        idle(2);
        run = 1'b0;
        idle(2);

        // reset mid-INTEG after a saturated output
        start_run(0, 2, 0);
        send(32767);
        exp_q.push_back(model(2 * 32767, 0));
        send(32767);
        send(3);
        check("pre_rst_sat_err", sat_err, 1);
        rst = 1'b1;
        run = 1'b0;
        idle(1);
        check("midrst_state", state_out, 0);
        check("midrst_val_out", val_out, 0);
        check("midrst_val_valid", val_valid, 0);
        check("midrst_sat_err", sat_err, 0);
        rst = 1'b0;
        send(4);
        send(5);
        idle(3);
        check("no_restart", state_out, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/adc_mac_integrator.md
ADC_MAC_INTEGRATOR -- requirements
Module: adc_mac_integrator

Interface
REQ-001 SHALL have parameter num_bits, default 16 (from ising_config): width of the signed two's-complement sample and output value.
REQ-002 SHALL have parameter acc_bits, default num_bits+8: width of the signed accumulator.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port run, input, 1: level enable, driven by the experiment FSM mac_run/nl_run.
REQ-006 SHALL have port adc_tdata, input, num_bits: signed ADC sample.
REQ-007 SHALL have port adc_tvalid, input, 1: sample strobe; no backpressure (ready tied high).
REQ-008 SHALL have port cfg_delay, input, 8: valid samples to discard after run start.
REQ-009 SHALL have port cfg_len, input, 8: valid samples summed per output.
REQ-010 SHALL have port cfg_shift, input, 4: arithmetic right shift applied to the sum.
REQ-011 SHALL have port val_out, output, num_bits: integrated value, feeds mac_val_in/nl_val_in.
REQ-012 SHALL have port val_valid, output, 1: one-cycle strobe marking val_out as new.
REQ-013 SHALL have port sat_err, output, 1: sticky saturation flag.
REQ-014 SHALL have port state_out, output, 2: current state encoding.

Function
REQ-015 SHALL implement states IDLE=0, DELAY=1, INTEG=2, reported on state_out.
REQ-016 SHALL, in IDLE with run=1, latch cfg_delay, cfg_len, cfg_shift, clear the accumulator and sample counter, clear sat_err, and enter DELAY if latched delay>0, else INTEG.
REQ-017 SHALL treat latched cfg_len=0 as 1.
REQ-018 SHALL ignore cfg_* changes while not in IDLE.
REQ-019 SHALL, in DELAY, count each cycle with adc_tvalid=1; on the cycle the count reaches the latched delay, enter INTEG with the counter cleared; that sample is discarded.
REQ-020 SHALL, in INTEG, add the sign-extended adc_tdata to the accumulator on each adc_tvalid=1 cycle and ignore cycles with adc_tvalid=0.
REQ-021 SHALL, on the cycle the len-th sample is accepted, register the result on val_out, assert val_valid the next cycle for exactly one cycle, and restart the accumulator at zero and the counter at zero, staying in INTEG. The result is (accumulator including that sample) >>> shift, saturated to num_bits.
REQ-022 SHALL accept a valid sample on the cycle immediately after the output cycle, with no dead cycle, giving an output period of len valid samples.
REQ-023 SHALL saturate to +2^(num_bits-1)-1 or -2^(num_bits-1) when the shifted sum exceeds num_bits range, and set sat_err.
REQ-024 SHALL hold val_out between strobes.
REQ-025 SHALL, when run=0 in DELAY or INTEG, return to IDLE on the next edge, discard any partial sum, and produce no val_valid. A completed output registered on that same edge still strobes.
REQ-026 SHALL not wrap the accumulator: acc_bits covers 255 samples at full scale.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, set state=IDLE, val_out=0, val_valid=0, sat_err=0, and clear the accumulator, counter and latched config; rst overrides run.
REQ-028 SHALL, on reset mid-INTEG, drop the partial sum with no strobe, and restart only on run=1 after rst deasserts.

Verification
REQ-029 Case: delay=3, len=4, shift=0, samples 1,2,...,11 continuously valid -> samples 1-3 discarded; val_out=4+5+6+7=22 with a 1-cycle strobe, then 8+9+10+11=38.
REQ-030 Case: len=2, shift=1, samples 100, -301 with a gap of adc_tvalid=0 between them -> val_out=-101 (arithmetic shift), one strobe, gap ignored.
REQ-031 Case: len=4, shift=0, four samples of 0x7FFF -> val_out=0x7FFF and sat_err=1; sat_err stays 1 until the next run start.
REQ-032 Case: len=0, delay=0, samples -5, 7 -> two strobes with val_out=-5 then 7.
REQ-033 Case: run drops after 2 of 4 samples, then rises again with delay=0, len=2, samples 10,20 -> no strobe for the partial sum; next val_out=30.
REQ-034 Case: rst=1 asserted mid-INTEG -> state_out=0, val_out=0, val_valid=0, sat_err=0 on the next cycle.
